// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory port: response owner, data width and the
// address range check used by the IF/MEM arbiter.
package cpu_mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // True when the byte address lies beyond a memory of 2**aw words.
  function automatic logic addr_out_of_range(input logic [XLEN-1:0] addr,
                                             input int unsigned aw);
    return (addr >> (aw + 2)) != '0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-macro command/response wires.
// slave = arbiter side, master = pipeline + memory side.
interface mem_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int MEM_AW = 12
);

  // Handshake: a stage holds req (and its address/data) until it sees gnt in
  // the same cycle; dropping req earlier is legal and withdraws the access.
  // Every gnt yields exactly one rvalid pulse in the following cycle.
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic              if_err;
  logic [XLEN-1:0]   if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic              d_err;
  logic [XLEN-1:0]   d_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_err, if_rdata,
           d_gnt, d_rvalid, d_err, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_err, if_rdata,
           d_gnt, d_rvalid, d_err, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_streak.sv
// Counts consecutive data grants while a fetch waits; asks for a forced fetch
// grant once STREAK_MAX is reached.
module mem_arb_streak #(
  parameter int STREAK_MAX = 4,
  localparam int SW = $clog2(STREAK_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_if_req,
  input  logic          i_if_gnt,
  input  logic          i_d_gnt,
  output logic          o_force_if,
  output logic [SW-1:0] o_streak
);

  logic [SW-1:0] r_streak;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_streak <= '0;
    end else if (!i_if_req || i_if_gnt) begin
      r_streak <= '0;
    end else if (i_d_gnt) begin
      r_streak <= r_streak + SW'(1);
    end
  end

  assign o_force_if = (r_streak == SW'(STREAK_MAX));
  assign o_streak   = r_streak;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port 1-cycle memory between IF and MEM stages, routes
// the response to its owner. Define MEM_ARB_FAIRNESS_EN for bounded fetch wait.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_AW     = 12,
  parameter int STREAK_MAX = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  mem_port_arbiter_if.slave                bus,
  output owner_e                           o_owner,
  output logic [$clog2(STREAK_MAX+1)-1:0]  o_dbg_streak
);

  logic   w_if_gnt;
  logic   w_d_gnt;
  logic   w_force_if;
  logic   w_if_oor;
  logic   w_d_oor;

  owner_e r_owner;
  logic   r_err;
  logic   r_store;
  owner_e w_owner_nxt;
  logic   w_err_nxt;
  logic   w_store_nxt;

  logic   w_if_rvalid;
  logic   w_d_rvalid;

  assign w_if_oor = addr_out_of_range(bus.if_addr, MEM_AW);
  assign w_d_oor  = addr_out_of_range(bus.d_addr, MEM_AW);

`ifdef MEM_ARB_FAIRNESS_EN
  mem_arb_streak #(
    .STREAK_MAX (STREAK_MAX)
  ) u_streak (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_if_req   (bus.if_req),
    .i_if_gnt   (w_if_gnt),
    .i_d_gnt    (w_d_gnt),
    .o_force_if (w_force_if),
    .o_streak   (o_dbg_streak)
  );
`else
  assign w_force_if   = 1'b0;
  assign o_dbg_streak = '0;
`endif

  // Data wins by default since MEM carries the older instruction.
  assign w_d_gnt  = reset_n && bus.d_req && !(bus.if_req && w_force_if);
  assign w_if_gnt = reset_n && bus.if_req && !w_d_gnt;

  assign bus.if_gnt = w_if_gnt;
  assign bus.d_gnt  = w_d_gnt;

  // Out-of-range accesses are granted but never reach the macro.
  assign bus.mem_en    = (w_d_gnt && !w_d_oor) || (w_if_gnt && !w_if_oor);
  assign bus.mem_we    = (w_d_gnt && bus.d_we && !w_d_oor) ? bus.d_be : '0;
  assign bus.mem_wdata = (w_d_gnt && bus.d_we) ? bus.d_wdata : '0;
  assign bus.mem_addr  = w_d_gnt  ? bus.d_addr[MEM_AW+1:2]  :
                         w_if_gnt ? bus.if_addr[MEM_AW+1:2] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_store <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_err   <= w_err_nxt;
      r_store <= w_store_nxt;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_err_nxt   = 1'b0;
    w_store_nxt = 1'b0;
    if (w_d_gnt) begin
      w_owner_nxt = OWN_D;
      w_err_nxt   = w_d_oor;
      w_store_nxt = bus.d_we;
    end else if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
      w_err_nxt   = w_if_oor;
    end
  end

  // Gating with reset_n drops a response whose grant preceded reset.
  assign w_if_rvalid = reset_n && (r_owner == OWN_IF);
  assign w_d_rvalid  = reset_n && (r_owner == OWN_D);

  assign bus.if_rvalid = w_if_rvalid;
  assign bus.if_err    = w_if_rvalid && r_err;
  assign bus.if_rdata  = (w_if_rvalid && !r_err) ? bus.mem_rdata : '0;

  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.d_err     = w_d_rvalid && r_err;
  assign bus.d_rdata   = (w_d_rvalid && !r_err && !r_store) ? bus.mem_rdata : '0;

  assign o_owner = r_owner;

  logic w_unused;
  assign w_unused = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle memory.
// Build with +define+MEM_ARB_FAIRNESS_EN to exercise the fairness variant.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int MEM_AW     = 12;
  localparam int STREAK_MAX = 4;

  logic clk;
  logic reset_n;
  owner_e owner;
  logic [$clog2(STREAK_MAX+1)-1:0] dbg_streak;

  mem_port_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

  mem_port_arbiter #(
    .MEM_AW     (MEM_AW),
    .STREAK_MAX (STREAK_MAX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .o_owner      (owner),
    .o_dbg_streak (dbg_streak)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  logic [31:0] mem_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      mem_q <= mem[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
  end
  assign bus.mem_rdata = mem_q;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
    chk(tag, got, exp);
  endtask

  // ---------------- driver ----------------
  // Inputs change just after a rising edge; checks happen on the falling edge.
  task automatic drive(input logic rn, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset_n     = rn;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_be    = be;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    @(negedge clk);
  endtask

  logic [9:0] fair_pat;

  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'h0;
    mem[4]  = 32'h0050_0093;
    mem[5]  = 32'h0000_0013;
    mem[8]  = 32'h1122_3344;
    mem[16] = 32'hCAFE_0000;
    mem_q   = 32'h0;
`ifdef MEM_ARB_FAIRNESS_EN
    fair_pat = 10'b10_0001_0000;
`else
    fair_pat = 10'b00_0000_0000;
`endif

    // Reset with both requests pending: everything held at zero.
    reset_n = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
    bus.d_addr = 32'h20; bus.d_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_d_gnt", bus.d_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_rvalid", {bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err}, 0);
    chk("rst_rdata", bus.if_rdata | bus.d_rdata, 0);
    chk("rst_owner", owner, OWN_NONE);
    chk("rst_streak", dbg_streak, 0);

    // Fetch only, granted in the first cycle out of reset.
    drive(1, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("fetch_if_gnt", bus.if_gnt, 1);
    chk("fetch_d_gnt", bus.d_gnt, 0);
    chk("fetch_mem_en", bus.mem_en, 1);
    chk("fetch_mem_addr", bus.mem_addr, 4);
    chk("fetch_no_early_rvalid", bus.if_rvalid, 0);
    exp_q.push_back(32'h0050_0093);
    drive(1, 0, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("fetch_rvalid", bus.if_rvalid, 1);
    chk_pop("fetch_rdata", bus.if_rdata);
    chk("fetch_err", bus.if_err, 0);
    chk("fetch_d_rvalid", bus.d_rvalid, 0);
    chk("idle_mem_en", bus.mem_en, 0);

    // Conflict: load wins, fetch follows once the load drops.
    drive(1, 1, 32'h14, 1, 0, 4'h0, 32'h20, 32'h0);
    chk("conf_d_gnt", bus.d_gnt, 1);
    chk("conf_if_gnt", bus.if_gnt, 0);
    chk("conf_mem_addr", bus.mem_addr, 8);
    chk("conf_mem_we", bus.mem_we, 0);
    exp_q.push_back(32'h1122_3344);
    drive(1, 1, 32'h14, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("conf_d_rvalid", bus.d_rvalid, 1);
    chk_pop("conf_d_rdata", bus.d_rdata);
    chk("conf_if_gnt2", bus.if_gnt, 1);
    chk("conf_mem_addr2", bus.mem_addr, 5);
    exp_q.push_back(32'h0000_0013);

    // Halfword store back-to-back with the fetch response.
    drive(1, 0, 32'h0, 1, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
    chk("st_if_rvalid", bus.if_rvalid, 1);
    chk_pop("st_if_rdata", bus.if_rdata);
    chk("st_d_gnt", bus.d_gnt, 1);
    chk("st_mem_we", bus.mem_we, 4'b0011);
    chk("st_mem_addr", bus.mem_addr, 16);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    drive(1, 0, 32'h0, 1, 0, 4'h0, 32'h40, 32'h0);
    chk("st_ack", bus.d_rvalid, 1);
    chk("st_ack_rdata", bus.d_rdata, 0);
    chk("st_ack_err", bus.d_err, 0);
    chk("reload_mem_we", bus.mem_we, 0);
    exp_q.push_back(32'hCAFE_BEEF);

    // Out-of-range load.
    drive(1, 0, 32'h0, 1, 0, 4'h0, 32'h0001_0000, 32'h0);
    chk("reload_rvalid", bus.d_rvalid, 1);
    chk_pop("reload_rdata", bus.d_rdata);
    chk("oor_d_gnt", bus.d_gnt, 1);
    chk("oor_mem_en", bus.mem_en, 0);
    drive(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("oor_rvalid", bus.d_rvalid, 1);
    chk("oor_err", bus.d_err, 1);
    chk("oor_rdata", bus.d_rdata, 0);

    // Fetch withdrawn before grant: no response for it.
    drive(1, 1, 32'h10, 1, 0, 4'h0, 32'h20, 32'h0);
    chk("drop_if_gnt", bus.if_gnt, 0);
    exp_q.push_back(32'h1122_3344);
    drive(1, 0, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("drop_d_rvalid", bus.d_rvalid, 1);
    chk_pop("drop_d_rdata", bus.d_rdata);
    chk("drop_if_rvalid", bus.if_rvalid, 0);
    drive(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("drop_quiet", {bus.if_rvalid, bus.d_rvalid}, 0);

    // Reset arriving while a fetch response is due.
    drive(1, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("rmid_if_gnt", bus.if_gnt, 1);
    drive(0, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("rmid_if_rvalid", bus.if_rvalid, 0);
    chk("rmid_if_rdata", bus.if_rdata, 0);
    chk("rmid_if_gnt2", bus.if_gnt, 0);
    chk("rmid_mem_en", bus.mem_en, 0);
    drive(1, 0, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("rmid_after", {bus.if_rvalid, bus.d_rvalid}, 0);

    // Both requesting continuously: grant pattern depends on fairness build.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 32'h10, 1, 0, 4'h0, 32'h20, 32'h0);
      chk($sformatf("fair_if_gnt[%0d]", i), bus.if_gnt, fair_pat[i]);
      chk($sformatf("fair_d_gnt[%0d]", i), bus.d_gnt, !fair_pat[i]);
    end
    drive(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("fair_streak_clear", dbg_streak, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Mutual exclusion of grants, checked every cycle.
  always @(negedge clk) begin
    if (bus.if_gnt && bus.d_gnt) chk("both_gnt", {bus.if_gnt, bus.d_gnt}, 2'b00);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port, one-cycle-latency on-chip memory of the RV32I pipelined CPU between the instruction-fetch (IF) stage and the data-memory (MEM) stage. Grants one access per cycle, steers the read response back to the owner one cycle later, and flags out-of-range addresses. Sits between the pipeline stages and the memory macro; a denied grant is the stage's stall source.

## Interface
- `MEM_AW`, default 12: memory word-address bits (4096 words = 16 KiB).
- `STREAK_MAX`, default 4: consecutive data grants tolerated while a fetch waits (fairness build only).
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch request; `if_addr` must hold stable until `if_gnt`.
- `if_addr` in 32: byte address; bits [1:0] ignored.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid`, `if_err` out 1: response valid / address out of range.
- `if_rdata` out 32: instruction word.
- `d_req`, `d_we` in 1: data request, 1 = store.
- `d_be` in 4: byte enables for stores.
- `d_addr`, `d_wdata` in 32: byte address, store data.
- `d_gnt`, `d_rvalid`, `d_err` out 1; `d_rdata` out 32: as for IF.
- `mem_en` out 1; `mem_we` out 4; `mem_addr` out MEM_AW; `mem_wdata` out 32: memory command.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_en`.

## Operation
- Grant is combinational from requests; everything is forced to 0 while `reset_n` is low.
- Default priority: data over fetch, because MEM holds the older instruction.
- Granted command drives the `mem_*` ports in the same cycle:
  - `mem_addr` = `addr[MEM_AW+1:2]`.
  - `mem_we` = `d_be` for a store, 0 otherwise.
- Range check: `addr[31:MEM_AW+2]` ≠ 0 makes the request out of range.
  - An out-of-range request is still granted, but `mem_en` = 0.
  - Its response is `err` = 1 with `rdata` = 0.
- Response tracking uses a registered owner field: NONE, IF, D, plus an `err` flag.
  - Owner transitions each cycle to whichever requester was granted, or to NONE if none was.
- Response outputs:
  - `rvalid` pulses for exactly one cycle to the owner.
  - `rdata` = `mem_rdata` when the owner is valid and there is no error, else 0.
  - A store also returns `d_rvalid` = 1 (write acknowledge), with `d_rdata` = 0.
- Back-to-back: a new grant is legal in the cycle a response returns; throughput is 1 access/cycle.
- Simultaneous `if_req` and `d_req`: exactly one grant, never both.

## Timing
- Request granted in cycle N → memory samples at the end of N → `rvalid`/`rdata` in N+1. Latency is 1 cycle.
- Reset values: `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `if_err`, `d_err`, `mem_en` and `mem_we` all 0; `rdata` = 0; owner = NONE; streak = 0.
- Reset asserted in cycle N while a grant is outstanding from N−1: the response is dropped, with no `rvalid` in N+1.
- First grant is possible in the first cycle with `reset_n` = 1.
- `req` dropped before `gnt`: legal; nothing is issued and no response follows.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A streak counter (width `$clog2(STREAK_MAX+1)`) increments on each data grant while `if_req` is denied.
  - When streak == `STREAK_MAX` and both request, IF is granted and streak clears.
  - Streak also clears on any fetch grant or when `if_req` = 0.
- Undefined: strict data priority; counter logic absent.

## Structure
- Shared package `cpu_mem_pkg`: owner enum (NONE, IF, D), `XLEN` = 32, byte-enable width, range-check helper function.
- Optional sub-module `mem_arb_streak`: the fairness counter, instantiated only under the macro.
- Everything else stays flat in `mem_port_arbiter`.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x10, mem word 4 = 0x00500093 → `if_gnt` in N; `if_rvalid`=1 and `if_rdata`=0x00500093 in N+1.
- Conflict: both request (load at 0x20) → `d_gnt`=1, `if_gnt`=0, `mem_addr`=8; `if_gnt`=1 next cycle once `d_req` drops.
- Store: `d_we`=1, `d_be`=0b0011, `d_addr`=0x40, `d_wdata`=0xDEADBEEF → `mem_we`=0b0011; `d_rvalid`=1, `d_rdata`=0 in N+1; a reload returns 0x????BEEF, upper bytes unchanged.
- Out of range: `d_addr`=0x0001_0000 → `d_gnt`=1, `mem_en`=0; `d_err`=1, `d_rdata`=0 in N+1.
- Reset mid-access: grant in N, `reset_n`=0 in N+1 → no `rvalid` in N+1; all outputs 0.
- Fairness (macro on, `STREAK_MAX`=4): `d_req` and `if_req` held high → D,D,D,D,IF,D,D,D,D,IF grant pattern; macro off → IF never granted.
